// File: rtl/ifu_fetch_buffer_pkg.sv
// Shared core parameters for the instruction-fetch buffer slice.
// Values mirror the legacy core_param.v macros.
package ifu_fetch_buffer_pkg;

  localparam int          InstAddrBus    = 32;
  localparam int          InstBus        = 32;
  localparam int          IFU_BUF_DEPTH  = 4;
  localparam logic        RESET_ENABLE   = 1'b0;
  localparam logic        PC_STOP_ENABLE = 1'b1;
  localparam logic [31:0] PC_START_ADDR  = 32'h0000_0000;

endpackage

// File: rtl/ifu_fetch_buffer_if.sv
// PC / instruction-memory / decode signals seen by the fetch buffer.
// The master side is the fetch buffer itself.
interface ifu_fetch_buffer_if
  import ifu_fetch_buffer_pkg::*;
#(
  parameter int AW = InstAddrBus,
  parameter int DW = InstBus
);

  logic [AW-1:0] pc_i;
  logic          flush_i;
  logic          pc_stopFlag_o;
  logic          imem_req_o;
  logic [AW-1:0] imem_addr_o;
  logic          imem_gnt_i;
  logic          imem_rvalid_i;
  logic [DW-1:0] imem_rdata_i;
  logic          inst_valid_o;
  logic [DW-1:0] inst_o;
  logic [AW-1:0] inst_addr_o;
  logic          id_ready_i;

  modport master (
    input  pc_i, flush_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_ready_i,
    output pc_stopFlag_o, imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_addr_o
  );

  modport slave (
    output pc_i, flush_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_ready_i,
    input  pc_stopFlag_o, imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_addr_o
  );

endinterface

// File: rtl/ifu_fetch_buffer_sync_fifo.sv
// Synchronous FIFO with clear; head is presented combinationally.
// Simultaneous push and pop at full is accepted.
module ifu_fetch_buffer_sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] cnt;
  logic          do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign count   = cnt;
  assign rdata   = mem[rptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (clr) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: readers only look at it while count is non-zero.
  always_ff @(posedge clk_i) begin
    if (do_push && !clr) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/ifu_fetch_buffer.sv
// Fetch responder: credit-limited imem requests, in-order response buffer,
// PC stop flag, and discard of in-flight fetches after a redirect.
module ifu_fetch_buffer
  import ifu_fetch_buffer_pkg::*;
#(
  parameter int DEPTH = IFU_BUF_DEPTH,
  parameter int AW    = InstAddrBus,
  parameter int DW    = InstBus
) (
  input  logic         clk_i,
  input  logic         rst_i,
  ifu_fetch_buffer_if.master bus
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_X = (CW+1)'(DEPTH);

  logic          in_rst, flush, credit_ok, req, grant, rsp, rsp_keep;
  logic          ib_valid, ib_pop;
  logic [CW-1:0] outstanding, discard, ib_cnt, aq_cnt;
  logic [AW-1:0] aq_head;
  logic [AW+DW-1:0] ib_head;
  logic          aq_full, aq_empty, ib_full, ib_empty;
  logic          unused_ok;

  assign in_rst    = (rst_i == RESET_ENABLE);
  assign flush     = bus.flush_i;
  assign credit_ok = ({1'b0, ib_cnt} + {1'b0, outstanding}) < DEPTH_X;
  assign req       = !in_rst && !flush && credit_ok && (discard == '0);
  assign grant     = req && bus.imem_gnt_i;
  // A response with nothing outstanding (e.g. left over from before reset) is ignored.
  assign rsp       = bus.imem_rvalid_i && (outstanding != '0);
  assign rsp_keep  = rsp && (discard == '0) && !flush;
  assign ib_valid  = !in_rst && !ib_empty;
  assign ib_pop    = ib_valid && bus.id_ready_i && !flush;

  assign bus.imem_req_o    = req;
  assign bus.imem_addr_o   = bus.pc_i;
  // Stop is forced low on flush: the PC must take the jump, not hold.
  assign bus.pc_stopFlag_o = in_rst ? PC_STOP_ENABLE : (!grant && !flush);
  assign bus.inst_valid_o  = ib_valid;
  assign bus.inst_o        = ib_valid ? ib_head[DW-1:0]     : '0;
  assign bus.inst_addr_o   = ib_valid ? ib_head[AW+DW-1:DW] : '0;

  ifu_fetch_buffer_sync_fifo #(.W(AW), .DEPTH(DEPTH)) u_addr_q (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr   (flush),
    .push  (grant),
    .pop   (rsp_keep),
    .wdata (bus.pc_i),
    .rdata (aq_head),
    .full  (aq_full),
    .empty (aq_empty),
    .count (aq_cnt)
  );

  ifu_fetch_buffer_sync_fifo #(.W(AW+DW), .DEPTH(DEPTH)) u_inst_buf (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr   (flush),
    .push  (rsp_keep),
    .pop   (ib_pop),
    .wdata ({aq_head, bus.imem_rdata_i}),
    .rdata (ib_head),
    .full  (ib_full),
    .empty (ib_empty),
    .count (ib_cnt)
  );

  assign unused_ok = ^{aq_full, aq_empty, aq_cnt, ib_full};

  // After a flush every remaining in-flight fetch is stale, so discard tracks outstanding.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (rst_i == RESET_ENABLE) begin
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + CW'(grant) - CW'(rsp);
      if (flush)
        discard <= outstanding - CW'(rsp);
      else if (rsp && (discard != '0))
        discard <= discard - CW'(1);
    end
  end

endmodule

// File: doc/ifu_fetch_buffer.md
Name: ifu_fetch_buffer

Overview:
Instruction-fetch responder that sits between the program counter and the instruction memory. It consumes the PC value, issues fetch requests with a req/gnt handshake, and buffers in-order responses with their addresses. It presents instructions to decode with a valid/ready handshake and returns a stop flag to the PC for backpressure. It also discards in-flight fetches when the PC is redirected.

Parameters:
DEPTH, 4, instruction buffer entries (power of 2, ≥2); also the maximum of outstanding requests plus buffered entries.
AW, 32, address width (`InstAddrBus`).
DW, 32, instruction width (`InstBus`).

Ports:
clk_i  input  1  clock.
rst_i  input  1  asynchronous reset, active-low (`RESET_ENABLE`).
pc_i  input  AW  current PC from the program counter.
flush_i  input  1  PC redirect this cycle; same signal as the PC's PCSel when it selects the ALU address.
pc_stopFlag_o  output  1  holds the PC when high.
imem_req_o  output  1  fetch request valid.
imem_addr_o  output  AW  fetch address; equals pc_i.
imem_gnt_i  input  1  memory accepts the request this cycle.
imem_rvalid_i  input  1  response valid, in request order, ≥1 cycle after grant.
imem_rdata_i  input  DW  response instruction.
inst_valid_o  output  1  buffer head valid.
inst_o  output  DW  head instruction.
inst_addr_o  output  AW  head instruction address.
id_ready_i  input  1  decode consumes the head when valid and ready are both high.

Behaviour:
- Reset (async, rst_i low): buffer empty, outstanding=0, discard=0. Outputs: inst_valid_o=0, inst_o=0, inst_addr_o=0, imem_req_o=0, pc_stopFlag_o=`PC_STOP_ENABLE`. Outputs must go to these values immediately on reset assertion, including mid-transaction; any response arriving after reset release with nothing outstanding is ignored.
- credit = DEPTH − (occupancy + outstanding). imem_req_o = !flush_i && credit>0 && discard==0.
- Grant (req && gnt): push pc_i into an address queue; outstanding+1.
- pc_stopFlag_o = !(imem_req_o && imem_gnt_i) && !flush_i. The stop flag is forced low during flush, because the PC gives stop priority over jump. The PC therefore advances exactly once per granted fetch.
- Response (rvalid) with discard==0: pop the address queue, write {addr,rdata} into the buffer, outstanding−1. The buffer never overflows, because it is guarded by credit.
- Response with discard>0: drop it, discard−1, outstanding−1.
- Dequeue: inst_valid_o = occupancy>0; on valid && ready, pop the head. Outputs are combinational from the head entry with registered storage. Latency is rvalid to inst_valid_o in 1 cycle.
- Flush (flush_i=1): buffer and address queue clear next cycle. discard ← outstanding − (rvalid this cycle ? 1 : 0). No request is issued that cycle. A decode pop coincident with flush is ignored, and its instruction is considered squashed.
- Simultaneous events:
  - Grant and response in the same cycle: outstanding is unchanged; the address queue pushes and pops.
  - Push and pop at full occupancy: legal; occupancy is unchanged.
  - Flush and grant are impossible, because req is low during flush.
- Pointers wrap modulo DEPTH. Occupancy and outstanding counters are $clog2(DEPTH)+1 bits wide.
- Stall persists while credit==0 or gnt is low; imem_addr_o holds stable while req is high and gnt is low.

Decomposition:
- `InstAddrBus`, `InstBus`, `RESET_ENABLE`, `PC_STOP_ENABLE` and `PC_START_ADDR` come from core_param.v.
- Add `IFU_BUF_DEPTH` to core_param.v.
- One natural sub-module: sync_fifo (parameterised width and depth, with push, pop, clear, full, empty and count). It is instantiated twice: once as the address queue (AW bits) and once as the instruction buffer (AW+DW bits).

Test Plan:
- Reset then gnt=1, rvalid 1 cycle later with rdata=0x00000013, id_ready=1 → requests at PC_START_ADDR, +4, +8; instructions emerge in order with matching inst_addr_o; stop stays low.
- id_ready=0, gnt=1 → exactly 4 grants, then req=0 and pc_stopFlag_o=1; release ready → one new request per pop.
- gnt held 0 for 3 cycles → imem_addr_o stable and stop=1 for 3 cycles; the PC does not advance.
- 2 outstanding, flush_i with pc_i=0x100 → stop=0 that cycle; buffer empties; both late responses dropped; first delivered instruction has addr 0x100.
- Flush coincident with rvalid and with 3 outstanding → discard=2; exactly 2 responses dropped.
- rst_i pulsed low with 2 buffered and 1 outstanding → inst_valid_o=0 immediately; after release, fetch restarts at PC_START_ADDR.
